// File: rtl/decoder_scan.sv
// Registered one-hot decoder with an auto-scan sequencer.
// In scan mode the active bit walks up or down, holding dwell+1 enabled cycles per step.
module decoder_scan #(
   parameter int SEL_W   = 3,
   parameter int DWELL_W = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    mode,
   input  logic [SEL_W-1:0]        sel_in,
   input  logic                    load,
   input  logic                    dir,
   input  logic [DWELL_W-1:0]      dwell,
   output logic [(1<<SEL_W)-1:0]   out,
   output logic [SEL_W-1:0]        idx,
   output logic                    wrap
);

   localparam int OUT_W = 1 << SEL_W;

   logic [DWELL_W-1:0] cnt;
   logic [DWELL_W-1:0] cnt_nxt;
   logic [SEL_W-1:0]   idx_nxt;
   logic               wrap_nxt;
   logic [OUT_W-1:0]   out_nxt;

   // Load and direct mode share one path; both restart the dwell count.
   always_comb begin
      idx_nxt  = idx;
      cnt_nxt  = cnt;
      wrap_nxt = 1'b0;
      if (load || !mode) begin
         idx_nxt = sel_in;
         cnt_nxt = '0;
      end else if (cnt >= dwell) begin
         cnt_nxt = '0;
         if (dir) begin
            idx_nxt  = idx - 1'b1;
            wrap_nxt = (idx == '0);
         end else begin
            idx_nxt  = idx + 1'b1;
            wrap_nxt = (idx == '1);
         end
      end else begin
         cnt_nxt = cnt + 1'b1;
      end
   end

   always_comb begin
      out_nxt          = '0;
      out_nxt[idx_nxt] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx  <= '0;
         cnt  <= '0;
         out  <= {{(OUT_W-1){1'b0}}, 1'b1};
         wrap <= 1'b0;
      end else if (en) begin
         idx  <= idx_nxt;
         cnt  <= cnt_nxt;
         out  <= out_nxt;
         wrap <= wrap_nxt;
      end else begin
         wrap <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: directed vector table, hand sequences, then random
// stimulus against a behavioural model of the index walk.
module tb_decoder_scan;

   logic       clk = 1'b0;
   logic       rst, en, mode, load, dir;
   logic [2:0] sel_in;
   logic [3:0] dwell;
   logic [7:0] out;
   logic [2:0] idx;
   logic       wrap;

   int checks = 0;
   int failures = 0;

   // Reference state: the index as a plain integer position on a ring of 8.
   int m_idx = 0, m_cnt = 0, m_wrap = 0;

   decoder_scan #(.SEL_W(3), .DWELL_W(4)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in),
      .load(load), .dir(dir), .dwell(dwell), .out(out), .idx(idx), .wrap(wrap)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst, en, mode, load, dir;
      logic [2:0] sel;
      logic [3:0] dwell;
      logic [7:0] exp_out;
      logic       exp_wrap;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_step();
      int nxt;
      if (rst) begin
         m_idx = 0; m_cnt = 0; m_wrap = 0;
      end else if (!en) begin
         m_wrap = 0;
      end else if (load || !mode) begin
         m_idx = int'(sel_in); m_cnt = 0; m_wrap = 0;
      end else if (m_cnt >= int'(dwell)) begin
         nxt = dir ? (m_idx + 7) % 8 : (m_idx + 1) % 8;
         // a wrap is a step that jumps the ring seam instead of moving by one
         m_wrap = (dir ? (nxt > m_idx) : (nxt < m_idx)) ? 1 : 0;
         m_idx = nxt; m_cnt = 0;
      end else begin
         m_cnt++; m_wrap = 0;
      end
   endtask

   task automatic cyc(input logic r, input logic e, input logic m, input logic l,
                      input logic d, input logic [2:0] s, input logic [3:0] dw);
      rst = r; en = e; mode = m; load = l; dir = d; sel_in = s; dwell = dw;
      @(posedge clk);
      #1;
      model_step();
      chk("model_out", int'(out), 1 << m_idx);
      chk("model_idx", int'(idx), m_idx);
      chk("model_wrap", int'(wrap), m_wrap);
   endtask

   task automatic add(input logic r, input logic e, input logic m, input logic l,
                      input logic d, input int s, input int dw, input int eo, input logic ew);
      vec_t v;
      v.rst = r; v.en = e; v.mode = m; v.load = l; v.dir = d;
      v.sel = 3'(s); v.dwell = 4'(dw); v.exp_out = 8'(eo); v.exp_wrap = ew;
      vecs.push_back(v);
   endtask

   initial begin
      rst = 1; en = 1; mode = 1; load = 0; dir = 0; sel_in = 0; dwell = 0;

      // reset held two cycles in scan mode
      add(1,1,1,0,0,0,0, 8'h01, 0);
      add(1,1,1,1,0,5,0, 8'h01, 0);
      // direct sweep
      for (int s = 0; s < 8; s++) add(0,1,0,0,0,s,0, 1 << s, 0);
      // scan up from 6, dwell 0
      add(0,1,1,1,0,6,0, 8'h40, 0);
      add(0,1,1,0,0,0,0, 8'h80, 0);
      add(0,1,1,0,0,0,0, 8'h01, 1);
      add(0,1,1,0,0,0,0, 8'h02, 0);
      // scan down from 1, dwell 2
      add(0,1,1,1,1,1,2, 8'h02, 0);
      add(0,1,1,0,1,0,2, 8'h02, 0);
      add(0,1,1,0,1,0,2, 8'h02, 0);
      add(0,1,1,0,1,0,2, 8'h01, 0);
      add(0,1,1,0,1,0,2, 8'h01, 0);
      add(0,1,1,0,1,0,2, 8'h01, 0);
      add(0,1,1,0,1,0,2, 8'h80, 1);
      add(0,1,1,0,1,0,2, 8'h80, 0);

      foreach (vecs[i]) begin
         cyc(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].load, vecs[i].dir,
             vecs[i].sel, vecs[i].dwell);
         chk($sformatf("vec%0d_out", i), int'(out), int'(vecs[i].exp_out));
         chk($sformatf("vec%0d_wrap", i), int'(wrap), int'(vecs[i].exp_wrap));
      end

      // reset release: first step lands dwell+1 cycles after rst drops
      cyc(1,1,1,0,0,0,3);
      cyc(1,1,1,0,0,0,3);
      for (int k = 0; k < 3; k++) cyc(0,1,1,0,0,0,3);
      chk("rel_hold", int'(out), 8'h01);
      cyc(0,1,1,0,0,0,3);
      chk("rel_step", int'(out), 8'h02);

      // load mid-dwell restarts the count, then en low freezes
      cyc(0,1,1,0,0,0,3);
      cyc(0,1,1,1,0,5,3);
      chk("ld_out", int'(out), 8'h20);
      for (int k = 0; k < 3; k++) cyc(0,1,1,0,0,0,3);
      chk("ld_hold", int'(out), 8'h20);
      cyc(0,1,1,0,0,0,3);
      chk("ld_step", int'(out), 8'h40);
      for (int k = 0; k < 5; k++) begin
         cyc(0,0,1,1,1,2,0);
         chk("en_freeze", int'(out), 8'h40);
         chk("en_wrap", int'(wrap), 0);
      end

      // dwell shrink below the running count forces a step
      cyc(0,1,1,1,0,3,9);
      for (int k = 0; k < 6; k++) cyc(0,1,1,0,0,0,9);
      chk("shr_hold", int'(out), 8'h08);
      cyc(0,1,1,0,0,0,2);
      chk("shr_step", int'(out), 8'h10);
      cyc(0,1,1,0,0,0,9);
      cyc(0,1,1,0,0,0,9);
      cyc(1,1,1,1,0,7,9);
      chk("rst_mid", int'(out), 8'h01);
      chk("rst_idx", int'(idx), 0);

      // random phase against the model
      for (int k = 0; k < 3000; k++) begin
         cyc(($urandom_range(0,99) < 2), ($urandom_range(0,99) < 85),
             ($urandom_range(0,99) < 80), ($urandom_range(0,99) < 5),
             1'($urandom), 3'($urandom),
             ($urandom_range(0,3) == 0) ? 4'($urandom) : 4'($urandom_range(0,3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
